sel_scan_ctrl: RTL and testbench
================================

Name: sel_scan_ctrl

Overview:
- Upstream stage of the 4-to-1 selector (mult4); drives its 2-bit sel input.
- Converts a raw, bouncing, active-low board key into a clean single-step advance of sel: 00->01->10->11->00.
- Optional auto-scan mode steps sel periodically so all four mux inputs are shown on the LED without user input.

Parameters:
- CLK_FREQ, 12_000_000, system clock frequency in Hz.
- DEBOUNCE_MS, 20, time the key must be stable before a level change is accepted, in ms.
- SCAN_MS, 500, auto-scan step period in ms.
- Derived: DB_CNT = CLK_FREQ/1000*DEBOUNCE_MS; SCAN_CNT = CLK_FREQ/1000*SCAN_MS. Both must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_n  input  1  raw push button, asynchronous, active-low (0 = pressed).
- auto_en  input  1  1 = auto-scan enabled, 0 = manual only; synchronous level.
- sel  output  2  selector code to mult4.
- sel_chg  output  1  one-cycle pulse, high in the first cycle sel holds a new value.

Behaviour:
- Reset (async, rst_n=0):
  - sel=2'b00, sel_chg=0.
  - Synchronizer flops=1 (released).
  - Debounce counter and scan counter = 0.
  - FSM in IDLE.
  - Effective immediately; a press in progress is discarded.
- Input sync: key_n passes through a 2-flop synchronizer; key_s is the second flop. Only key_s is used downstream.
- Debounce FSM, states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; counter db_cnt:
  - IDLE: key_s=0 -> PRESS_WAIT, db_cnt=0.
  - PRESS_WAIT:
    - key_s=1 -> IDLE (bounce rejected).
    - Else db_cnt increments; when db_cnt reaches DB_CNT-1 with key_s still 0 -> HELD and assert key_step for one cycle.
  - HELD: key_s=1 -> RELEASE_WAIT, db_cnt=0. Holding the key never generates further steps.
  - RELEASE_WAIT:
    - key_s=0 -> HELD (release bounce).
    - Else count; at DB_CNT-1 -> IDLE.
- Scan counter:
  - auto_en=0: scan_cnt held at 0, no auto steps.
  - auto_en=1: scan_cnt counts 0..SCAN_CNT-1, wraps to 0, and asserts scan_step on the wrap cycle.
- Step merge:
  - step = key_step | scan_step.
  - A key_step also clears scan_cnt to 0, restarting the auto period.
  - key_step and scan_step in the same cycle produce exactly one increment.
- Output update:
  - On step, sel <= sel+1 (modulo 4, 11 wraps to 00) at the next rising edge.
  - sel_chg is registered and high for exactly that one cycle.
  - Latency from key_s first low to sel change = DB_CNT+1 cycles; add 2 synchronizer cycles from key_n.
- auto_en toggling 1->0 mid-period: scan_cnt clears the next cycle and no pending step is issued. 0->1: the first auto step comes SCAN_CNT cycles later.
- sel is always a registered output, glitch-free.

Optional Feature:
- Macro SEL_SCAN_REVERSE_EN.
- Defined:
  - Adds input port key_dn_n (1-bit, active-low) after key_n, with its own synchronizer and debounce FSM of identical behaviour.
  - Its debounced press decrements sel (00 wraps to 11), pulses sel_chg, and clears scan_cnt.
  - Up and down presses accepted in the same cycle cancel: sel unchanged, sel_chg=0, scan_cnt still cleared.
  - An auto step coinciding with a lone down press: the down press wins (net -1).
- Undefined: port absent, behaviour exactly as above.

Test Plan:
All scenarios use CLK_FREQ=1000, DEBOUNCE_MS=4 (DB_CNT=4), SCAN_MS=10 (SCAN_CNT=10), auto_en=0 unless stated.
- Reset: hold rst_n=0 with key_n=0 toggling -> sel=00, sel_chg=0 throughout. Release, key_n=1 -> sel stays 00.
- Clean press: key_n=0 for 20 cycles -> sel 00->01 exactly DB_CNT+3=7 cycles after the key_n falling edge; sel_chg high one cycle; no further change while held.
- Bounce: key_n toggles low 2 cycles / high 1 cycle for 12 cycles, then high -> sel unchanged, sel_chg never asserted.
- Wrap: 4 clean press/release pairs (each 10 low / 10 high) -> sel sequence 01,10,11,00; four sel_chg pulses.
- Auto-scan: auto_en=1 for 45 cycles -> sel steps every 10 cycles (4 steps, ends 00). A clean press at cycle 25 steps immediately, and the next auto step is 10 cycles after that press step.
- Mid-operation reset: rst_n pulsed low during PRESS_WAIT and again at sel=10 -> sel=00 asynchronously; no step issued after release until a new full debounce.

Source files
------------

// File: rtl/sel_scan_ctrl.sv
// sel_scan_ctrl: debounced key / periodic auto-scan stepping of the 2-bit mult4 selector.
// Define SEL_SCAN_REVERSE_EN to add the key_dn_n down-step key.
module sel_scan_ctrl #(
  parameter int unsigned CLK_FREQ    = 12_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned SCAN_MS     = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
`ifdef SEL_SCAN_REVERSE_EN
  input  logic       key_dn_n,
`endif
  input  logic       auto_en,
  output logic [1:0] sel,
  output logic       sel_chg
);

  localparam int unsigned DB_CNT   = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int unsigned SCAN_CNT = CLK_FREQ / 1000 * SCAN_MS;
  localparam int unsigned DBW      = $clog2(DB_CNT);
  localparam int unsigned SCW      = $clog2(SCAN_CNT);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CNT - 1);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_CNT - 1);

`ifdef SEL_SCAN_REVERSE_EN
  localparam int unsigned NKEY = 2;
`else
  localparam int unsigned NKEY = 1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_e;

  logic [NKEY-1:0] key_raw;
  logic [NKEY-1:0] sync1_q;
  logic [NKEY-1:0] key_s_q;
  logic [NKEY-1:0] key_step;
  db_state_e       state_q  [NKEY];
  db_state_e       state_d  [NKEY];
  logic [DBW-1:0]  db_cnt_q [NKEY];
  logic [DBW-1:0]  db_cnt_d [NKEY];

  logic [SCW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            sel_chg_q, sel_chg_d;
  logic            up_step, dn_step, key_hit, scan_step;

`ifdef SEL_SCAN_REVERSE_EN
  assign key_raw = {key_dn_n, key_n};
  assign dn_step = key_step[1];
`else
  assign key_raw = key_n;
  assign dn_step = 1'b0;
`endif
  assign up_step = key_step[0];
  assign key_hit = up_step | dn_step;

  // Each key: 2-flop synchronizer (reset to released) feeding its own debounce FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      key_s_q <= '1;
      for (int unsigned k = 0; k < NKEY; k++) begin
        state_q[k]  <= IDLE;
        db_cnt_q[k] <= '0;
      end
    end else begin
      sync1_q <= key_raw;
      key_s_q <= sync1_q;
      for (int unsigned k = 0; k < NKEY; k++) begin
        state_q[k]  <= state_d[k];
        db_cnt_q[k] <= db_cnt_d[k];
      end
    end
  end

  always_comb begin
    key_step = '0;
    for (int unsigned k = 0; k < NKEY; k++) begin
      state_d[k]  = state_q[k];
      db_cnt_d[k] = db_cnt_q[k];
      unique case (state_q[k])
        IDLE: begin
          if (!key_s_q[k]) begin
            state_d[k]  = PRESS_WAIT;
            db_cnt_d[k] = '0;
          end
        end
        PRESS_WAIT: begin
          if (key_s_q[k]) begin
            state_d[k] = IDLE;
          end else if (db_cnt_q[k] == DB_LAST) begin
            state_d[k]  = HELD;
            key_step[k] = 1'b1;
          end else begin
            db_cnt_d[k] = db_cnt_q[k] + 1'b1;
          end
        end
        HELD: begin
          if (key_s_q[k]) begin
            state_d[k]  = RELEASE_WAIT;
            db_cnt_d[k] = '0;
          end
        end
        RELEASE_WAIT: begin
          if (!key_s_q[k]) begin
            state_d[k] = HELD;
          end else if (db_cnt_q[k] == DB_LAST) begin
            state_d[k] = IDLE;
          end else begin
            db_cnt_d[k] = db_cnt_q[k] + 1'b1;
          end
        end
        default: state_d[k] = IDLE;
      endcase
    end
  end

  assign scan_step = auto_en && (scan_cnt_q == SCAN_LAST);

  // Simultaneous up and down presses cancel each other and any coinciding auto step.
  always_comb begin
    sel_d     = sel_q;
    sel_chg_d = 1'b0;
    if (dn_step && !up_step) begin
      sel_d     = sel_q - 2'd1;
      sel_chg_d = 1'b1;
    end else if (!dn_step && (up_step || scan_step)) begin
      sel_d     = sel_q + 2'd1;
      sel_chg_d = 1'b1;
    end
    if (!auto_en || key_hit || scan_step) begin
      scan_cnt_d = '0;
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= 2'b00;
      sel_chg_q  <= 1'b0;
      scan_cnt_q <= '0;
    end else begin
      sel_q      <= sel_d;
      sel_chg_q  <= sel_chg_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

  assign sel     = sel_q;
  assign sel_chg = sel_chg_q;

endmodule

// File: tb/tb_sel_scan_ctrl.sv
// Self-checking bench for sel_scan_ctrl: run-length key model plus directed literal checks.
module tb_sel_scan_ctrl;

  localparam int DB   = 4;
  localparam int SCAN = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic       auto_en = 1'b0;
  logic [1:0] sel;
  logic       sel_chg;

  int total = 0;
  int bad = 0;

  sel_scan_ctrl #(
    .CLK_FREQ   (1000),
    .DEBOUNCE_MS(4),
    .SCAN_MS    (10)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_n),
    .auto_en(auto_en),
    .sel    (sel),
    .sel_chg(sel_chg)
  );

  always #5 clk = ~clk;

  // Reference model: a press is accepted once the synchronized key has been low for
  // DB+1 consecutive cycles while released; it is released again after DB+1 high cycles.
  bit m_s1 = 1'b1, m_ks = 1'b1, m_armed = 1'b1, m_chg = 1'b0;
  int m_low = 0, m_high = 0, m_since = 0, m_sel = 0;

  always @(posedge clk or negedge rst_n) begin
    bit kstep, sstep;
    if (!rst_n) begin
      m_s1 = 1'b1; m_ks = 1'b1; m_armed = 1'b1;
      m_low = 0; m_high = 0; m_since = 0; m_sel = 0; m_chg = 1'b0;
    end else begin
      kstep = m_armed && (m_low == DB + 1);
      sstep = auto_en && (m_since == SCAN - 1);
      if (kstep) m_armed = 1'b0;
      else if (!m_armed && m_high == DB + 1) m_armed = 1'b1;
      m_since = (!auto_en || kstep || sstep) ? 0 : m_since + 1;
      m_chg = kstep || sstep;
      if (m_chg) m_sel = (m_sel + 1) % 4;
      m_ks = m_s1;
      m_s1 = key_n;
      if (m_ks) begin m_high++; m_low = 0; end
      else begin m_low++; m_high = 0; end
    end
  end

  task automatic tick();
    logic [1:0] exp_sel;
    @(negedge clk);
    exp_sel = 2'(m_sel);
    total++;
    if (sel !== exp_sel || sel_chg !== m_chg) begin
      bad++;
      $display("FAIL model t=%0t: sel=%0d sel_chg=%0b expected sel=%0d sel_chg=%0b",
               $time, sel, sel_chg, exp_sel, m_chg);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input int low, input int high);
    key_n = 1'b0;
    repeat (low) tick();
    key_n = 1'b1;
    repeat (high) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    int pulses[$];
    int run;

    // Reset held with key activity
    for (int i = 0; i < 8; i++) begin
      key_n = i[0];
      tick();
    end
    chk("reset_sel", 32'(sel), 0);
    chk("reset_chg", 32'(sel_chg), 0);
    rst_n = 1'b1;
    key_n = 1'b1;
    repeat (10) tick();
    chk("post_reset_sel", 32'(sel), 0);

    // Clean press: change lands on the 7th rising edge after key_n falls
    key_n = 1'b0;
    repeat (6) tick();
    chk("press_early_sel", 32'(sel), 0);
    tick();
    chk("press_sel", 32'(sel), 1);
    chk("press_chg_on", 32'(sel_chg), 1);
    tick();
    chk("press_chg_off", 32'(sel_chg), 0);
    repeat (12) tick();
    chk("held_sel", 32'(sel), 1);
    key_n = 1'b1;
    repeat (10) tick();

    // Bounce: low 2 / high 1 never lasts long enough
    n = 0;
    for (int i = 0; i < 12; i++) begin
      key_n = (i % 3 == 2);
      tick();
      if (sel_chg) n++;
    end
    key_n = 1'b1;
    repeat (10) begin tick(); if (sel_chg) n++; end
    chk("bounce_sel", 32'(sel), 1);
    chk("bounce_pulses", 32'(n), 0);

    // Wrap through all four codes
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      press(10, 10);
      chk("wrap_sel", 32'(sel), 32'(i % 4));
    end

    // Auto-scan alone
    do_reset();
    auto_en = 1'b1;
    n = 0;
    for (int i = 0; i < 45; i++) begin tick(); if (sel_chg) n++; end
    auto_en = 1'b0;
    chk("auto_pulses", 32'(n), 4);
    chk("auto_sel", 32'(sel), 0);

    // Auto-scan with a press stepping at cycle 25 and restarting the period
    do_reset();
    auto_en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (sel_chg) pulses.push_back(i);
      if (i == 18) key_n = 1'b0;
      if (i == 30) key_n = 1'b1;
    end
    auto_en = 1'b0;
    chk("auto_press_count", 32'(pulses.size()), 4);
    if (pulses.size() == 4) begin
      chk("auto_p0", 32'(pulses[0]), 10);
      chk("auto_p1", 32'(pulses[1]), 20);
      chk("auto_p2", 32'(pulses[2]), 25);
      chk("auto_p3", 32'(pulses[3]), 35);
    end
    repeat (10) tick();

    // Mid-operation reset during PRESS_WAIT, key kept low through release
    do_reset();
    press(10, 10);
    key_n = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1 chk("async_rst_pw_sel", 32'(sel), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    key_n = 1'b1;
    repeat (10) tick();
    chk("no_step_after_rst", 32'(sel), 0);
    // Mid-operation reset at sel=10
    press(10, 10);
    press(10, 10);
    chk("pre_rst_sel", 32'(sel), 2);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_sel", 32'(sel), 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // Randomized key, auto_en and reset activity against the model
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (run == 0) begin
        key_n = ~key_n;
        run = $urandom_range(1, 14);
      end else begin
        run--;
      end
      if ($urandom_range(0, 59) == 0) auto_en = ~auto_en;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
